// File: rtl/matrix_loader_if.sv
// Stream-in / matrix-out bundle between an element source and the matrix loader.
// dbg_state and dbg_idx mirror the loader's FSM registers so checkers can bind to them.
interface matrix_loader_if #(
   parameter int WIDTH = 8,
   parameter int ELEMS = 9
);
   logic [WIDTH-1:0]             in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic                         restart;
   logic [ELEMS-1:0][WIDTH-1:0]  matrix_a;
   logic [ELEMS-1:0][WIDTH-1:0]  matrix_b;
   logic                         w_en;
   logic                         a_done;
   logic [1:0]                   dbg_state;
   logic [3:0]                   dbg_idx;

   // An element moves on a rising edge where in_valid and in_ready are both 1.
   // in_ready depends only on loader state, never on in_valid; restart wins over a
   // simultaneous transfer, and that cycle's element is dropped.
   modport master (
      output in_data, in_valid, restart,
      input  in_ready, matrix_a, matrix_b, w_en, a_done, dbg_state, dbg_idx
   );

   modport slave (
      input  in_data, in_valid, restart,
      output in_ready, matrix_a, matrix_b, w_en, a_done, dbg_state, dbg_idx
   );
endinterface

// File: rtl/matrix_loader.sv
// Loads two row-major 3x3 matrices (A then B) from an element stream and holds
// them stable, with w_en high, until restart or reset.
module matrix_loader #(
   parameter int WIDTH = 8,
   parameter int ELEMS = 9
) (
   input logic          clk,
   input logic          rst,
   matrix_loader_if.slave bus
);
   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(ELEMS - 1);

   state_t                       state;
   logic [3:0]                   idx;
   logic [ELEMS-1:0][WIDTH-1:0]  mat_a;
   logic [ELEMS-1:0][WIDTH-1:0]  mat_b;
   logic                         w_en_q;
   logic                         a_done_q;
   logic                         xfer;

   assign bus.in_ready  = (state != DONE);
   assign xfer          = bus.in_valid && bus.in_ready;

   assign bus.matrix_a  = mat_a;
   assign bus.matrix_b  = mat_b;
   assign bus.w_en      = w_en_q;
   assign bus.a_done    = a_done_q;
   assign bus.dbg_state = state;
   assign bus.dbg_idx   = idx;

   // Flags are registered alongside the state so they change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD_A;
         idx      <= '0;
         mat_a    <= '0;
         mat_b    <= '0;
         w_en_q   <= 1'b0;
         a_done_q <= 1'b0;
      end else if (bus.restart) begin
         // Storage is kept; the next load overwrites it element by element.
         state    <= LOAD_A;
         idx      <= '0;
         w_en_q   <= 1'b0;
         a_done_q <= 1'b0;
      end else if (xfer) begin
         case (state)
            LOAD_A: begin
               mat_a[idx] <= bus.in_data;
               if (idx == LAST_IDX) begin
                  state    <= LOAD_B;
                  idx      <= '0;
                  a_done_q <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            LOAD_B: begin
               mat_b[idx] <= bus.in_data;
               if (idx == LAST_IDX) begin
                  state  <= DONE;
                  idx    <= '0;
                  w_en_q <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader, with a registered 3x3 multiplier model standing
// in for the downstream consumer of w_en.
module tb_matrix_loader;
   localparam int WIDTH = 8;
   localparam int ELEMS = 9;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [ELEMS-1:0][WIDTH-1:0] exp_a;
   logic [ELEMS-1:0][WIDTH-1:0] exp_b;
   logic [ELEMS-1:0][17:0]      prod;
   logic [ELEMS-1:0][17:0]      exp_prod;

   matrix_loader_if #(.WIDTH(WIDTH), .ELEMS(ELEMS)) bus ();

   matrix_loader #(.WIDTH(WIDTH), .ELEMS(ELEMS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream multiplier model: C = A x B, latched on each w_en cycle.
   always @(posedge clk) begin
      if (bus.w_en) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               prod[r*3+c] <= 18'(bus.matrix_a[r*3+0]) * 18'(bus.matrix_b[0*3+c])
                            + 18'(bus.matrix_a[r*3+1]) * 18'(bus.matrix_b[1*3+c])
                            + 18'(bus.matrix_a[r*3+2]) * 18'(bus.matrix_b[2*3+c]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      prod          = '0;
      rst           = 1'b1;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.restart   = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_state",  256'(bus.dbg_state), 256'(0));
      check("rst_idx",    256'(bus.dbg_idx),   256'(0));
      check("rst_ready",  256'(bus.in_ready),  256'(1));
      check("rst_w_en",   256'(bus.w_en),      256'(0));
      check("rst_a_done", 256'(bus.a_done),    256'(0));
      check("rst_mat_a",  256'(bus.matrix_a),  256'(0));
      check("rst_mat_b",  256'(bus.matrix_b),  256'(0));

      // Continuous stream: A = 1..9, B = 9..1
      for (int i = 0; i < 9; i++) begin
         exp_a[i] = 8'(i + 1);
         exp_b[i] = 8'(9 - i);
      end
      for (int i = 0; i < 9; i++) begin
         send(exp_a[i]);
         if (i == 7) check("cont_a_done_early", 256'(bus.a_done), 256'(0));
      end
      check("cont_a_done",   256'(bus.a_done),    256'(1));
      check("cont_state_b",  256'(bus.dbg_state), 256'(1));
      for (int i = 0; i < 9; i++) begin
         send(exp_b[i]);
         if (i == 7) check("cont_w_en_early", 256'(bus.w_en), 256'(0));
      end
      check("cont_w_en",     256'(bus.w_en),      256'(1));
      check("cont_state_d",  256'(bus.dbg_state), 256'(2));
      check("cont_ready",    256'(bus.in_ready),  256'(0));
      check("cont_mat_a",    256'(bus.matrix_a),  256'(exp_a));
      check("cont_mat_b",    256'(bus.matrix_b),  256'(exp_b));

      // DONE ignores input
      for (int i = 0; i < 5; i++) begin
         send(8'hFF);
         check("done_ready", 256'(bus.in_ready), 256'(0));
      end
      bus.in_valid = 1'b0;
      check("done_mat_a", 256'(bus.matrix_a), 256'(exp_a));
      check("done_mat_b", 256'(bus.matrix_b), 256'(exp_b));
      check("done_w_en",  256'(bus.w_en),     256'(1));

      // Reset, then the same stream with in_valid toggling 1,0,1,0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_mat_a", 256'(bus.matrix_a), 256'(0));
      for (int k = 0; k < 18; k++) begin
         send((k < 9) ? exp_a[k] : exp_b[k-9]);
         if (k == 16) check("gap_w_en_early", 256'(bus.w_en), 256'(0));
         if (k == 17) check("gap_w_en",       256'(bus.w_en), 256'(1));
         bus.in_valid = 1'b0;
         bus.in_data  = 8'h5A;
         tick();
         check("gap_idx", 256'(bus.dbg_idx), 256'((k + 1) % 9));
      end
      check("gap_mat_a", 256'(bus.matrix_a), 256'(exp_a));
      check("gap_mat_b", 256'(bus.matrix_b), 256'(exp_b));

      // Restart colliding with the 5th element of B
      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      check("rs_w_en",   256'(bus.w_en),   256'(0));
      check("rs_a_done", 256'(bus.a_done), 256'(0));
      for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
      for (int i = 0; i < 4; i++) send(8'(8'h20 + i));
      bus.in_data = 8'hAA;
      bus.restart = 1'b1;
      tick();
      bus.restart  = 1'b0;
      bus.in_valid = 1'b0;
      check("rsb_state",  256'(bus.dbg_state),   256'(0));
      check("rsb_idx",    256'(bus.dbg_idx),     256'(0));
      check("rsb_w_en",   256'(bus.w_en),        256'(0));
      check("rsb_a_done", 256'(bus.a_done),      256'(0));
      check("rsb_b3",     256'(bus.matrix_b[3]), 256'(8'h23));
      check("rsb_b4",     256'(bus.matrix_b[4]), 256'(8'h05));
      send(8'h77);
      bus.in_valid = 1'b0;
      check("rsb_next_a0", 256'(bus.matrix_a[0]), 256'(8'h77));
      check("rsb_next_a1", 256'(bus.matrix_a[1]), 256'(8'h11));
      check("rsb_next_idx", 256'(bus.dbg_idx),    256'(1));

      // Reset after 12 transfers
      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      for (int i = 0; i < 12; i++) send(8'(8'h30 + i));
      bus.in_valid = 1'b0;
      check("mid_a_done", 256'(bus.a_done),  256'(1));
      check("mid_idx",    256'(bus.dbg_idx), 256'(3));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_mat_a",  256'(bus.matrix_a),  256'(0));
      check("mid_rst_mat_b",  256'(bus.matrix_b),  256'(0));
      check("mid_rst_w_en",   256'(bus.w_en),      256'(0));
      check("mid_rst_a_done", 256'(bus.a_done),    256'(0));
      check("mid_rst_state",  256'(bus.dbg_state), 256'(0));

      // Full reload: A = identity, B = 1..9, then the multiplier result
      for (int i = 0; i < 9; i++) begin
         exp_a[i]    = ((i / 3) == (i % 3)) ? 8'd1 : 8'd0;
         exp_b[i]    = 8'(i + 1);
         exp_prod[i] = 18'(i + 1);
      end
      for (int i = 0; i < 9; i++) send(exp_a[i]);
      for (int i = 0; i < 9; i++) send(exp_b[i]);
      bus.in_valid = 1'b0;
      check("mm_w_en",  256'(bus.w_en),     256'(1));
      check("mm_mat_a", 256'(bus.matrix_a), 256'(exp_a));
      check("mm_mat_b", 256'(bus.matrix_b), 256'(exp_b));
      tick();
      check("mm_prod",  256'(prod),         256'(exp_prod));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter: WIDTH, 8, bit width of each matrix element and of in_data.
REQ-002 Parameter: ELEMS, 9, elements per matrix (3x3, row-major); other values are not supported.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  stream element.
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-008 Port: restart  input  1  single-cycle request to begin a new load.
REQ-009 Port: matrix_a  output  [ELEMS-1:0] x WIDTH  operand A; element e is row e/3, column e%3.
REQ-010 Port: matrix_b  output  [ELEMS-1:0] x WIDTH  operand B; same layout as matrix_a.
REQ-011 Port: w_en  output  1  both matrices complete and stable; enables the downstream multiplier.
REQ-012 Port: a_done  output  1  matrix_a complete; matrix_b loading or complete.

Function
REQ-013 States: LOAD_A, LOAD_B, DONE; state and idx are registered; idx is a 4-bit element counter, 0..8.
REQ-014 Transfer occurs on a clock edge when in_valid=1 and in_ready=1; no other cycle writes matrix storage.
REQ-015 in_ready = 1 in LOAD_A and LOAD_B, 0 in DONE; combinational from state only, never from in_valid.
REQ-016 LOAD_A transfer: matrix_a[idx] <= in_data; idx increments; at idx=8 the state becomes LOAD_B and idx becomes 0.
REQ-017 LOAD_B transfer: matrix_b[idx] <= in_data; idx increments; at idx=8 the state becomes DONE and idx becomes 0.
REQ-018 w_en = 1 exactly when the state is DONE; the first w_en cycle follows the edge that accepts the 18th element (latency 1 cycle).
REQ-019 a_done = 1 in LOAD_B and DONE, 0 in LOAD_A.
REQ-020 A cycle with in_valid=0 leaves state, idx and storage unchanged; gaps of any length are allowed.
REQ-021 In DONE, in_valid is ignored and matrix_a/matrix_b hold their values indefinitely.
REQ-022 restart=1 in any state: next state LOAD_A, idx=0, w_en deasserts on the next cycle; storage is not cleared and is overwritten element by element.
REQ-023 restart has priority over a simultaneous transfer; that cycle's in_data is dropped even though in_ready=1.
REQ-024 in_data passes to storage unmodified; no arithmetic or width conversion is performed.

Reset
REQ-025 rst=1 at an edge: state LOAD_A, idx=0, all matrix_a/matrix_b elements 0, w_en=0, a_done=0.
REQ-026 rst has priority over restart and over transfers; the first accepted element after reset is written to matrix_a[0].
REQ-027 Reset asserted mid-load discards partial contents and zeroes storage.

Verification
REQ-028 Reset, then stream 1..9 followed by 9..1 with in_valid held at 1 -> a_done rises after 9 transfers; w_en rises on the cycle after the 18th transfer; matrix_a={1..9} and matrix_b={9..1} by index.
REQ-029 Same stream with in_valid toggling 1,0,1,0 -> identical final contents; w_en rises the cycle after the last accepted element.
REQ-030 In DONE, drive in_valid=1 with data 0xFF for 5 cycles -> in_ready=0; contents and w_en unchanged.
REQ-031 restart pulsed at the same edge as the 5th element of B (value 0xAA) -> next cycle state LOAD_A, w_en=0, a_done=0, matrix_b[4] unchanged; the next element goes to matrix_a[0].
REQ-032 rst asserted after 12 transfers -> all elements 0, w_en=0, a_done=0; a full 18-element reload completes normally.
REQ-033 Connect to the downstream multiplier; load A=identity, B={1..9} -> the multiplier's result equals {1..9} one cycle after w_en rises.
